mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_pkg.sv | 19 +
 rtl/mem_bist_patgen.sv | 36 +++
 rtl/mem_bist_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST controller.
// Holds the FSM state encoding and pattern select codes.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_INV   = 2'd2,
    PAT_ONES  = 2'd3
  } pat_e;

endpackage

// File: rtl/mem_bist_patgen.sv
// Expected-data generator for the memory BIST.
// Pure combinational map from (address, pattern) to a data word.
module mem_bist_patgen
  import mem_bist_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  pat_e                  pat,
  output logic [WIDTH-1:0]      data
);

  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] chk;

  always_comb begin
    ext = WIDTH'(addr);
    chk = '0;
    // even address gives ...1010, odd address gives ...0101
    for (int i = 0; i < WIDTH; i++) begin
      chk[i] = i[0] ^ addr[0];
    end
  end

  always_comb begin
    data = '0;
    unique case (pat)
      PAT_ADDR:  data = ext;
      PAT_CHECK: data = chk;
      PAT_INV:   data = ~ext;
      PAT_ONES:  data = '1;
    endcase
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: write pass then read/compare pass
// over the whole memory, with a per-transfer ready watchdog.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            pattern_i,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WDW-1:0] WD_LIM =
    WDW'(TIMEOUT - 1);

  state_e                state_q, state_d;
  pat_e                  pat_q, pat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  to_q, to_d;
  logic                  pass_q, pass_d;
  logic                  done_q, done_d;

  logic [WIDTH-1:0] exp_data;
  logic             busy;
  logic             xfer;
  logic             mis;

  mem_bist_patgen #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_patgen (
    .addr (addr_q),
    .pat  (pat_q),
    .data (exp_data)
  );

  assign busy = (state_q == S_WRITE) ||
                (state_q == S_READ);
  assign xfer = busy & ready_i;
  assign mis  = (rdata_i != exp_data);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    addr_d  = addr_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    wd_d    = wd_q;
    to_d    = to_q;
    pass_d  = pass_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_WRITE;
          pat_d   = pat_e'(pattern_i);
          addr_d  = '0;
          err_d   = '0;
          ferr_d  = '0;
          wd_d    = '0;
          to_d    = 1'b0;
          pass_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_WRITE, S_READ: begin
        if (xfer) begin
          wd_d = '0;
          if (state_q == S_READ && mis) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) ferr_d = addr_q;
          end
          if (addr_q == LAST) begin
            addr_d = '0;
            if (state_q == S_WRITE) begin
              state_d = S_READ;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              pass_d  = (err_d == '0);
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else if (wd_q == WD_LIM) begin
          // memory stopped answering: abort the run
          state_d = S_DONE;
          wd_d    = '0;
          to_d    = 1'b1;
          pass_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pat_q   <= PAT_ADDR;
      addr_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign valid_o          = busy;
  assign busy_o           = busy;
  assign wr_rd_o          = (state_q == S_WRITE);
  assign addr_o           = busy ? addr_q : '0;
  assign wdata_o          = wr_rd_o ? exp_data : '0;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign timeout_o        = to_q;
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = ferr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Randomized bench for mem_bist_ctrl with a
// behavioural memory and reference model.
module tb_mem_bist_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int TMO   = 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    pattern_i = 2'd0;
  logic          valid_o;
  logic          wr_rd_o;
  logic [AW-1:0] addr_o;
  logic [15:0]   wdata_o;
  logic [15:0]   rdata_i = '0;
  logic          ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic          timeout_o;
  logic [AW:0]   err_cnt_o;
  logic [AW-1:0] first_err_addr_o;

  mem_bist_ctrl #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .pattern_i        (pattern_i),
    .valid_o          (valid_o),
    .wr_rd_o          (wr_rd_o),
    .addr_o           (addr_o),
    .wdata_o          (wdata_o),
    .rdata_i          (rdata_i),
    .ready_i          (ready_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .timeout_o        (timeout_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_data(
    input int a, input int p);
    case (p)
      0:       return 16'(a);
      1:       return (a % 2 == 0) ? 16'hAAAA
                                   : 16'h5555;
      2:       return 16'hFFFF - 16'(a);
      default: return 16'hFFFF;
    endcase
  endfunction

  // memory model and reference state
  int          mode = 0;
  int          lat = 0;
  int          cur_pat = 0;
  bit          corrupt [DEPTH];
  logic [15:0] mem [DEPTH];
  int          n_xfer = 0;
  int          m_err = 0;
  int          m_ferr = -1;
  int          wait_cnt = 0;
  int          stall_run = 0;
  int          max_stall = 0;
  int          first_valid_cyc = -1;
  int          cyc = 0;
  bit          p_valid = 0;
  bit          p_ready = 0;
  logic [25:0] p_req = '0;
  logic [15:0] rd;
  bit          rdy;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial forever begin
    @(negedge clk_i);
    if (!valid_o || !wr_rd_o)
      chk("wdata_zero", wdata_o, 0);
    if (!valid_o) begin
      ready_i   = 1'b0;
      rdata_i   = 16'($urandom);
      wait_cnt  = 0;
      stall_run = 0;
      p_valid   = 0;
    end else begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (p_valid && !p_ready)
        chk("stable", {wr_rd_o, addr_o, wdata_o}, p_req);
      case (mode)
        0:       rdy = (wait_cnt >= lat);
        1:       rdy = (wait_cnt >= 5) ||
                       ($urandom_range(0, 2) == 0);
        default: rdy = (n_xfer < 9);
      endcase
      ready_i = rdy;
      if (rdy) begin
        wait_cnt  = 0;
        stall_run = 0;
        chk("seq_addr", addr_o, n_xfer % DEPTH);
        chk("seq_dir", wr_rd_o, n_xfer < DEPTH);
        if (wr_rd_o) begin
          chk("wdata", wdata_o,
              ref_data(int'(addr_o), cur_pat));
          mem[addr_o] = wdata_o;
          rdata_i = 16'($urandom);
        end else begin
          rd = mem[addr_o] ^
               (corrupt[addr_o] ? 16'h0100 : 16'h0);
          rdata_i = rd;
          if (rd != ref_data(int'(addr_o), cur_pat)) begin
            m_err++;
            if (m_ferr < 0) m_ferr = int'(addr_o);
          end
        end
        n_xfer++;
      end else begin
        wait_cnt++;
        stall_run++;
        if (stall_run > max_stall) max_stall = stall_run;
        rdata_i = 16'($urandom);
      end
      p_valid = 1;
      p_ready = rdy;
      p_req   = {wr_rd_o, addr_o, wdata_o};
    end
  end

  task automatic start_run(input int p, input int md,
                           input int lt);
    @(negedge clk_i);
    mode            = md;
    lat             = lt;
    cur_pat         = p;
    n_xfer          = 0;
    m_err           = 0;
    m_ferr          = -1;
    max_stall       = 0;
    first_valid_cyc = -1;
    pattern_i       = 2'(p);
    start_i         = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
    pattern_i = 2'($urandom);
  endtask

  task automatic wait_done(input bit mid_start,
                           output int done_cyc);
    int k = 0;
    while (!done_o && k < 20000) begin
      @(negedge clk_i);
      k++;
      if (mid_start && k == 100) begin
        start_i   = 1'b1;
        pattern_i = 2'(cur_pat + 1);
      end
      if (k == 102) start_i = 1'b0;
    end
    done_cyc = cyc;
    chk("done_reached", done_o, 1);
  endtask

  task automatic check_result(input bit exp_to);
    chk("done", done_o, 1);
    chk("busy", busy_o, 0);
    chk("valid", valid_o, 0);
    chk("timeout", timeout_o, exp_to);
    chk("pass", pass_o, !exp_to && m_err == 0);
    chk("err_cnt", err_cnt_o, m_err);
    chk("first_err", first_err_addr_o,
        (m_ferr < 0) ? 0 : m_ferr);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {valid_o, wr_rd_o, addr_o, wdata_o,
              busy_o, done_o, pass_o, timeout_o,
              err_cnt_o, first_err_addr_o}, 64'd0);
  endtask

  task automatic watch_no_valid(input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    chk("no_valid_idle", seen, 0);
  endtask

  int  dc;
  bit  hit;
  int  nbad;

  initial begin
    foreach (corrupt[i]) corrupt[i] = 0;
    repeat (3) @(posedge clk_i);
    #1 check_all_zero("reset_outs");
    @(negedge clk_i);
    rst_i = 1'b1;
    watch_no_valid(10);

    // zero wait, address pattern
    start_run(0, 0, 0);
    wait_done(0, dc);
    check_result(0);
    chk("latency", dc - first_valid_cyc, 1024);
    chk("xfers", n_xfer, 1024);
    chk("max_stall0", max_stall, 0);

    // 3-cycle latency, checkerboard
    start_run(1, 0, 3);
    wait_done(0, dc);
    check_result(0);
    chk("mem0", mem[0], 16'hAAAA);
    chk("mem1", mem[1], 16'h5555);
    chk("pass_lat3", pass_o, 1);
    chk("max_stall3", max_stall, 3);

    // two corrupted reads
    corrupt[5]     = 1;
    corrupt[9'h1F0] = 1;
    start_run(2, 0, 0);
    wait_done(0, dc);
    check_result(0);
    chk("err2", err_cnt_o, 2);
    chk("ferr5", first_err_addr_o, 5);
    chk("pass_err", pass_o, 0);
    foreach (corrupt[i]) corrupt[i] = 0;

    // memory hangs on the 10th write
    start_run(3, 2, 0);
    wait_done(0, dc);
    check_result(1);
    chk("stall_len", max_stall, TMO);
    chk("writes_before_hang", n_xfer, 9);

    // reset in the middle of the read pass
    start_run(0, 1, 0);
    hit = 0;
    for (int i = 0; i < 8000 && !hit; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o && !wr_rd_o && addr_o == 9'h100) begin
        rst_i = 1'b0;
        hit   = 1;
        #1 check_all_zero("midrun_reset");
      end
    end
    chk("reached_read_100", hit, 1);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    watch_no_valid(20);
    start_run(3, 0, 1);
    wait_done(0, dc);
    check_result(0);
    chk("pass_after_rst", pass_o, 1);

    // start pulse while busy is ignored
    start_run(1, 0, 0);
    wait_done(1, dc);
    check_result(0);
    chk("xfers_midstart", n_xfer, 1024);

    // randomized runs from DONE
    for (int r = 0; r < 3; r++) begin
      nbad = $urandom_range(0, 3);
      for (int j = 0; j < nbad; j++)
        corrupt[$urandom_range(0, DEPTH - 1)] = 1;
      start_run($urandom_range(0, 3), 1, 0);
      wait_done(0, dc);
      check_result(0);
      chk("xfers_rand", n_xfer, 1024);
      foreach (corrupt[i]) corrupt[i] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
